simplez_loader: RTL and testbench
=================================

Name: simplez_loader

Overview:
- Boot loader sitting directly upstream of the Simplez processor.
- Consumes a byte stream from the UART receiver, assembles 12-bit words, and writes them into the processor's program RAM (9-bit address) from address 0.
- Holds the processor in reset while loading. Releases it only after a frame passes its checksum, and answers each frame with one ack byte to the UART transmitter.

Parameters:
TIMEOUT, 12_000_000, max clk cycles between bytes inside a frame before the frame is aborted (1 s at 12 MHz)
BOOT_RUN, 1, 1: cpu_rstn released after rst (runs preloaded ROM image); 0: cpu held in reset until first good load

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  ack byte
tx_start  out  1  one-cycle strobe to transmitter
tx_ready  in  1  transmitter idle
mem_addr  out  9  RAM write address
mem_din  out  12  RAM write data
mem_we  out  1  RAM write enable, one cycle per word
cpu_rstn  out  1  processor reset, active low
busy  out  1  frame in progress (any state but IDLE/RUN)
loaded  out  1  last frame accepted (sticky until next START)
err  out  1  last frame rejected (sticky until next START)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state IDLE (or RUN if BOOT_RUN=1); tx_start=0, tx_data=0, mem_we=0, mem_addr=0, mem_din=0, busy=0, loaded=0, err=0; cpu_rstn=BOOT_RUN.
- Frame format:
  - START 0x53
  - LEN_H: bits[7:2] must be 0
  - LEN_L: N = {LEN_H[1:0], LEN_L}, valid range 1..512
  - N word pairs: HI byte with bits[7:4] ignored, word[11:8]=HI[3:0]; LO byte gives word[7:0]
  - CHK byte
- CHK must equal the 8-bit wrapping sum of LEN_H, LEN_L and all data bytes (START and CHK excluded).
- States and transitions:
  - IDLE/RUN: non-START bytes are ignored. A START byte sets cpu_rstn=0, clears loaded/err and the sum, sets addr=0, then goes to LEN_H.
  - LEN_H → LEN_L → DATA_H (N valid) or ERR (N=0, N>512, or LEN_H[7:2]≠0).
  - DATA_H → DATA_L. On the LO byte, mem_we=1 for exactly the cycle after that rx_valid, with mem_addr = word index and mem_din = assembled word. The address then increments. Go to CHK after word N-1, otherwise back to DATA_H.
  - CHK: a match goes to ACK with tx_data=0x4B 'K'; a mismatch goes to ERR.
  - ERR: sets tx_data=0x45 'E', then goes to ACK.
  - ACK: waits for tx_ready. tx_start pulses for one cycle when tx_ready=1.
    - After a 'K': loaded=1, cpu_rstn=1, state RUN.
    - After an 'E': err=1, cpu_rstn stays 0, state IDLE.
- Timeout: a counter cleared on each rx_valid, counting only in LEN_H..CHK. Reaching TIMEOUT goes to ERR.
- rx_valid in ACK or ERR is dropped. 0x53 inside a frame is treated as data, not a restart.
- The address never wraps; N≤512 guarantees this. RAM contents after an error are undefined, but the cpu is held in reset.
- rst mid-frame aborts the frame: outputs take their reset values, and no tx or mem_we is emitted.
- The address counter is 10 bits internally; mem_addr is its low 9 bits.

Decomposition:
- Header loader.vh holds: START=8'h53, ACK_OK=8'h4B, ACK_ERR=8'h45, the state encodings, and MAX_WORDS=512.
- One natural sub-module, loader_timeout: a restartable down-counter with clear/enable and an expire pulse. Its width is derived from TIMEOUT.

Test Plan:
1. Good 2-word load: bytes 53 00 02 01 23 0E 00 34 → writes addr0=0x123, addr1=0xE00, each mem_we one cycle after its LO strobe. Then tx 0x4B, loaded=1, cpu_rstn=1.
2. Bad checksum: same frame with CHK=0x35 → both writes occur, tx 0x45, err=1, cpu_rstn=0, state IDLE.
3. Length errors:
   - 53 00 00 → tx 0x45.
   - 53 02 01 (N=513) → tx 0x45.
   - 53 02 00 with 512 words and correct CHK → last write at addr 0x1FF, tx 0x4B.
4. Timeout: TIMEOUT=100, send 53 00 01 01, then stall 100 cycles → tx 0x45, err=1, no further mem_we.
5. Ack handshake: tx_ready=0 for 20 cycles at ACK → tx_start stays low and rx bytes are ignored. tx_start pulses once on the cycle tx_ready rises.
6. Reset behaviour:
   - rst asserted after the LO byte of word 0 → no tx_start, cpu_rstn=BOOT_RUN, busy=0.
   - With BOOT_RUN=0: a garbage byte stream without 0x53 keeps cpu_rstn=0 and mem_we=0.

Source files
------------

// File: rtl/simplez_loader_pkg.sv
// Shared constants and state encoding for the Simplez boot loader.
// Frame: START, LEN_H, LEN_L, N x (HI, LO), CHK.
package simplez_loader_pkg;

  localparam logic [7:0] START   = 8'h53;
  localparam logic [7:0] ACK_OK  = 8'h4B;
  localparam logic [7:0] ACK_ERR = 8'h45;
  localparam int         MAX_WORDS = 512;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RUN,
    S_LEN_H,
    S_LEN_L,
    S_DATA_H,
    S_DATA_L,
    S_CHK,
    S_ERR,
    S_ACK
  } state_t;

  function automatic logic len_ok(
    input logic [7:0] len_h,
    input logic [9:0] n
  );
    return (len_h[7:2] == 6'd0) && (n != 10'd0) &&
           (n <= 10'(MAX_WORDS));
  endfunction

endpackage

// File: rtl/simplez_loader_timeout.sv
// Restartable inter-byte watchdog for the boot loader.
// Pulses expire after TIMEOUT enabled cycles without a clear.
module loader_timeout #(
  parameter int unsigned TIMEOUT = 12_000_000,
  localparam int W = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || !en || cnt == '0)
      cnt <= W'(TIMEOUT - 1);
    else
      cnt <= cnt - 1'b1;
  end

  assign expire = en && !clr && (cnt == '0);

endmodule

// File: rtl/simplez_loader.sv
// Simplez boot loader: UART byte frames into program RAM,
// holding the cpu in reset until a frame passes its checksum.
module simplez_loader
  import simplez_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 12_000_000,
  parameter bit          BOOT_RUN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic [8:0]  mem_addr,
  output logic [11:0] mem_din,
  output logic        mem_we,
  output logic        cpu_rstn,
  output logic        busy,
  output logic        loaded,
  output logic        err
);

  state_t      state, nxt;
  logic [7:0]  sum;
  logic [7:0]  len_h;
  logic [9:0]  len;
  logic [9:0]  addr;
  logic [3:0]  hi;
  logic [9:0]  n;
  logic        in_frame;
  logic        expire;

  assign n = {len_h[1:0], rx_data};

  loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (rx_valid),
    .en    (in_frame),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= BOOT_RUN ? S_RUN : S_IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_RUN:
        if (rx_valid && rx_data == START) nxt = S_LEN_H;
      S_LEN_H:
        if (rx_valid)    nxt = S_LEN_L;
        else if (expire) nxt = S_ERR;
      S_LEN_L:
        if (rx_valid)
          nxt = len_ok(len_h, n) ? S_DATA_H : S_ERR;
        else if (expire)
          nxt = S_ERR;
      S_DATA_H:
        if (rx_valid)    nxt = S_DATA_L;
        else if (expire) nxt = S_ERR;
      S_DATA_L:
        if (rx_valid)
          nxt = (addr + 10'd1 == len) ? S_CHK : S_DATA_H;
        else if (expire)
          nxt = S_ERR;
      S_CHK:
        if (rx_valid)
          nxt = (rx_data == sum) ? S_ACK : S_ERR;
        else if (expire)
          nxt = S_ERR;
      S_ERR:
        nxt = S_ACK;
      S_ACK:
        if (tx_ready)
          nxt = (tx_data == ACK_OK) ? S_RUN : S_IDLE;
      default:
        nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = !(state inside {S_IDLE, S_RUN});
    in_frame = state inside {S_LEN_H, S_LEN_L, S_DATA_H,
                             S_DATA_L, S_CHK};
  end

  // Datapath: the registered outputs and frame bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 9'd0;
      mem_din  <= 12'd0;
      cpu_rstn <= BOOT_RUN;
      loaded   <= 1'b0;
      err      <= 1'b0;
      sum      <= 8'd0;
      len_h    <= 8'd0;
      len      <= 10'd0;
      addr     <= 10'd0;
      hi       <= 4'd0;
    end else begin
      tx_start <= 1'b0;
      mem_we   <= 1'b0;
      unique case (state)
        S_IDLE, S_RUN:
          if (rx_valid && rx_data == START) begin
            cpu_rstn <= 1'b0;
            loaded   <= 1'b0;
            err      <= 1'b0;
            sum      <= 8'd0;
            addr     <= 10'd0;
          end
        S_LEN_H:
          if (rx_valid) begin
            len_h <= rx_data;
            sum   <= sum + rx_data;
          end
        S_LEN_L:
          if (rx_valid) begin
            len <= n;
            sum <= sum + rx_data;
          end
        S_DATA_H:
          if (rx_valid) begin
            hi  <= rx_data[3:0];
            sum <= sum + rx_data;
          end
        S_DATA_L:
          if (rx_valid) begin
            mem_we   <= 1'b1;
            mem_addr <= addr[8:0];
            mem_din  <= {hi, rx_data};
            addr     <= addr + 10'd1;
            sum      <= sum + rx_data;
          end
        S_CHK:
          if (rx_valid && rx_data == sum) tx_data <= ACK_OK;
        S_ERR:
          tx_data <= ACK_ERR;
        S_ACK:
          if (tx_ready) begin
            tx_start <= 1'b1;
            if (tx_data == ACK_OK) begin
              loaded   <= 1'b1;
              cpu_rstn <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simplez_loader.sv
// Scoreboard bench for simplez_loader.
// Writes and ack bytes are queued by stimulus and popped by a monitor.
module tb_simplez_loader;

  typedef struct packed {
    logic [8:0]  a;
    logic [11:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;
  logic [8:0]  mem_addr;
  logic [11:0] mem_din;
  logic        mem_we;
  logic        cpu_rstn;
  logic        busy;
  logic        loaded;
  logic        err;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int tx_cnt = 0;
  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  logic       rxv_q = 1'b0;
  logic       we_prev = 1'b0;

  simplez_loader #(
    .TIMEOUT (100),
    .BOOT_RUN(1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_ready(tx_ready),
    .mem_addr(mem_addr),
    .mem_din (mem_din),
    .mem_we  (mem_we),
    .cpu_rstn(cpu_rstn),
    .busy    (busy),
    .loaded  (loaded),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) rxv_q <= rx_valid;

  // Monitor: compare every write and every ack byte with the queues.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_cnt++;
      chk("we_after_lo", {31'd0, rxv_q}, 32'd1);
      chk("we_one_cycle", {31'd0, we_prev}, 32'd0);
      if (exp_wr.size() == 0) begin
        chk("wr_unexpected", {11'd0, mem_addr, mem_din}, 32'hFFFFFFFF);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_addr", {23'd0, mem_addr}, {23'd0, e.a});
        chk("wr_data", {20'd0, mem_din}, {20'd0, e.d});
      end
    end
    if (tx_start) begin
      tx_cnt++;
      if (exp_tx.size() == 0)
        chk("tx_unexpected", {24'd0, tx_data}, 32'hFFFFFFFF);
      else
        chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
    end
    we_prev <= mem_we;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    chk({nm, "_txq"}, exp_tx.size(), 0);
    chk({nm, "_wrq"}, exp_wr.size(), 0);
  endtask

  task automatic flags(input string nm, input logic l,
                       input logic e, input logic c);
    chk({nm, "_loaded"}, {31'd0, loaded}, {31'd0, l});
    chk({nm, "_err"}, {31'd0, err}, {31'd0, e});
    chk({nm, "_cpu_rstn"}, {31'd0, cpu_rstn}, {31'd0, c});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] s;
    logic [11:0] d;
    int n0;

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst_mem_din", {20'd0, mem_din}, 32'd0);
    flags("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Good 2-word load
    exp_wr.push_back('{9'd0, 12'h123});
    exp_wr.push_back('{9'd1, 12'hE00});
    exp_tx.push_back(8'h4B);
    send_bytes('{8'h53, 8'h00, 8'h02, 8'h01, 8'h23,
                 8'h0E, 8'h00, 8'h34});
    wait_done("good");
    flags("good", 1'b1, 1'b0, 1'b1);

    // Bad checksum
    exp_wr.push_back('{9'd0, 12'h123});
    exp_wr.push_back('{9'd1, 12'hE00});
    exp_tx.push_back(8'h45);
    send_bytes('{8'h53, 8'h00, 8'h02, 8'h01, 8'h23,
                 8'h0E, 8'h00, 8'h35});
    wait_done("badchk");
    flags("badchk", 1'b0, 1'b1, 1'b0);

    // Length errors
    exp_tx.push_back(8'h45);
    send_bytes('{8'h53, 8'h00, 8'h00});
    wait_done("len0");
    flags("len0", 1'b0, 1'b1, 1'b0);
    exp_tx.push_back(8'h45);
    send_bytes('{8'h53, 8'h02, 8'h01});
    wait_done("len513");
    flags("len513", 1'b0, 1'b1, 1'b0);
    exp_tx.push_back(8'h45);
    send_bytes('{8'h53, 8'h04, 8'h01});
    wait_done("lenh_bits");

    // Full 512-word load; HI upper nibble is junk but summed
    q = '{8'h53, 8'h02, 8'h00};
    s = 8'h02;
    for (int i = 0; i < 512; i++) begin
      d = 12'((i * 7 + 3) ^ (i << 3));
      q.push_back({4'hA, d[11:8]});
      q.push_back(d[7:0]);
      s = s + {4'hA, d[11:8]} + d[7:0];
      exp_wr.push_back('{9'(i), d});
    end
    q.push_back(s);
    exp_tx.push_back(8'h4B);
    send_bytes(q);
    wait_done("len512");
    flags("len512", 1'b1, 1'b0, 1'b1);

    // Inter-byte timeout mid-word
    n0 = wr_cnt;
    exp_tx.push_back(8'h45);
    send_bytes('{8'h53, 8'h00, 8'h01, 8'h01});
    chk("tmo_busy_early", {31'd0, busy}, 32'd1);
    wait_done("timeout");
    flags("timeout", 1'b0, 1'b1, 1'b0);
    chk("tmo_no_we", wr_cnt, n0);

    // Ack handshake held off by tx_ready
    tx_ready = 1'b0;
    exp_wr.push_back('{9'd0, 12'hABC});
    exp_tx.push_back(8'h4B);
    send_bytes('{8'h53, 8'h00, 8'h01, 8'h0A, 8'hBC, 8'hC7});
    n0 = tx_cnt;
    send_bytes('{8'h53, 8'h00});
    repeat (16) @(negedge clk);
    chk("ack_hold_tx", tx_cnt, n0);
    chk("ack_hold_busy", {31'd0, busy}, 32'd1);
    tx_ready = 1'b1;
    wait_done("ack");
    chk("ack_one_pulse", tx_cnt, n0 + 1);
    flags("ack", 1'b1, 1'b0, 1'b1);

    // Reset mid-frame after word 0 LO byte
    exp_wr.push_back('{9'd0, 12'h123});
    n0 = tx_cnt;
    send_bytes('{8'h53, 8'h00, 8'h02, 8'h01, 8'h23});
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    flags("mid_rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    chk("mid_rst_no_tx", tx_cnt, n0);
    chk("mid_rst_wrq", exp_wr.size(), 0);

    // Garbage without START leaves cpu held
    n0 = wr_cnt;
    send_bytes('{8'h00, 8'hFF, 8'h12, 8'h4B, 8'h45, 8'hAA, 8'h01});
    repeat (5) @(negedge clk);
    chk("garb_no_we", wr_cnt, n0);
    chk("garb_busy", {31'd0, busy}, 32'd0);
    chk("garb_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
    chk("end_txq", exp_tx.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
